// File: rtl/hysteretic_gating_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hysteretic_gating_ctrl_if
//  Description : Per-channel valid/ready capture bus for the hysteretic
//                clock-gating controller. The master drives valid and data.
//                The slave (the controller) returns ready.
//  Ports       : ch_valid [NUM_CH]       - per-channel data valid
//                ch_data  [NUM_CH*WIDTH] - per-channel data, channel i at
//                                          [i*WIDTH +: WIDTH]
//                ch_ready [NUM_CH]       - per-channel accept indication
//  Revision    : 1.0 - initial release
// ============================================================================
interface hysteretic_gating_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
);
  logic [NUM_CH-1:0]       ch_valid;
  logic [NUM_CH*WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]       ch_ready;

  modport master (
    output ch_valid,
    output ch_data,
    input  ch_ready
  );

  modport slave (
    input  ch_valid,
    input  ch_data,
    output ch_ready
  );
endinterface
`default_nettype wire

// File: rtl/hysteretic_gating_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hysteretic_gating_ctrl
//  Description : Multi-channel capture register bank with a per-channel
//                hysteretic clock-gating controller. A channel drops its clock
//                enable after IDLE_CYCLES consecutive idle cycles in RUN. It
//                returns through WAKE_CYCLES wake-up cycles before it accepts
//                data again. Saturating counters record the cycles spent gated.
//  Ports       : clk          - clock
//                rst_n        - asynchronous active-low reset
//                ch_if        - slave side of the valid/data/ready bus
//                force_on     - per-channel gating override
//                gate_disable - global gating override
//                clr_stats    - synchronous clear of all gated-cycle counters
//                ch_data_out  - captured data per channel
//                clk_en       - per-channel clock enable for downstream ICG
//                ch_gated     - per-channel gated status
//                gated_cnt    - per-channel saturating gated-cycle counters
//  Revision    : 1.0 - initial release
// ============================================================================
module hysteretic_gating_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 32,
  parameter int IDLE_CYCLES = 8,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  hysteretic_gating_ctrl_if.slave   ch_if,
  input  logic [NUM_CH-1:0]         force_on,
  input  logic                      gate_disable,
  input  logic                      clr_stats,
  output logic [NUM_CH*WIDTH-1:0]   ch_data_out,
  output logic [NUM_CH-1:0]         clk_en,
  output logic [NUM_CH-1:0]         ch_gated,
  output logic [NUM_CH*CNT_W-1:0]   gated_cnt
);

  localparam int C_IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int C_WAKE_W = (WAKE_CYCLES < 1) ? 1 : $clog2(WAKE_CYCLES + 1);

  localparam logic [C_IDLE_W-1:0] C_IDLE_LAST = C_IDLE_W'(IDLE_CYCLES - 1);
  // Clamped so the constant stays legal when WAKE is never entered.
  localparam logic [C_WAKE_W-1:0] C_WAKE_LAST =
    C_WAKE_W'((WAKE_CYCLES == 0) ? 0 : (WAKE_CYCLES - 1));
  localparam logic [CNT_W-1:0]    C_CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_GATED = 2'b01,
    ST_WAKE  = 2'b10
  } state_t;

  logic [NUM_CH-1:0] w_ready;
  logic [NUM_CH-1:0] w_clk_en;

  assign ch_if.ch_ready = w_ready;
  assign clk_en         = w_clk_en;
  assign ch_gated       = ~w_clk_en;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t              r_state;
    state_t              w_state_nxt;
    logic [C_IDLE_W-1:0] r_idle_cnt;
    logic [C_IDLE_W-1:0] w_idle_cnt_nxt;
    logic [C_WAKE_W-1:0] r_wake_cnt;
    logic [C_WAKE_W-1:0] w_wake_cnt_nxt;
    logic [WIDTH-1:0]    r_data;
    logic [CNT_W-1:0]    r_gated_cnt;
    logic                w_accept;
    logic                w_act;
    logic                w_wake_req;

    // Ready and clock enable are decodes of the state flops only. As a result
    // the enable feeding the ICG has no combinational path from the inputs.
    assign w_ready[i]  = (r_state == ST_RUN);
    assign w_clk_en[i] = (r_state != ST_GATED);

    assign w_accept   = ch_if.ch_valid[i] & w_ready[i];
    assign w_act      = w_accept | force_on[i] | gate_disable;
    assign w_wake_req = ch_if.ch_valid[i] | force_on[i] | gate_disable;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state    <= ST_RUN;
        r_idle_cnt <= '0;
        r_wake_cnt <= '0;
      end else begin
        r_state    <= w_state_nxt;
        r_idle_cnt <= w_idle_cnt_nxt;
        r_wake_cnt <= w_wake_cnt_nxt;
      end
    end

    always_comb begin
      w_state_nxt    = r_state;
      w_idle_cnt_nxt = r_idle_cnt;
      w_wake_cnt_nxt = r_wake_cnt;
      unique case (r_state)
        ST_RUN: begin
          // Activity wins over the terminal idle count on the same edge.
          if (w_act) begin
            w_idle_cnt_nxt = '0;
          end else if (r_idle_cnt == C_IDLE_LAST) begin
            w_state_nxt    = ST_GATED;
            w_idle_cnt_nxt = '0;
          end else begin
            w_idle_cnt_nxt = r_idle_cnt + 1'b1;
          end
        end
        ST_GATED: begin
          if (w_wake_req) begin
            if (WAKE_CYCLES == 0) begin
              w_state_nxt = ST_RUN;
            end else begin
              w_state_nxt    = ST_WAKE;
              w_wake_cnt_nxt = '0;
            end
          end
        end
        ST_WAKE: begin
          // The wake-up delay always runs to completion. Overrides do not
          // shorten it.
          if (r_wake_cnt == C_WAKE_LAST) begin
            w_state_nxt    = ST_RUN;
            w_wake_cnt_nxt = '0;
          end else begin
            w_wake_cnt_nxt = r_wake_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt    = ST_RUN;
          w_idle_cnt_nxt = '0;
          w_wake_cnt_nxt = '0;
        end
      endcase
    end

    // Capture register. It loads only on an accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data <= '0;
      end else if (w_accept) begin
        r_data <= ch_if.ch_data[i*WIDTH +: WIDTH];
      end
    end

    // Gated-residency counter. The clear has priority, and the count holds at
    // all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_gated_cnt <= '0;
      end else if (clr_stats) begin
        r_gated_cnt <= '0;
      end else if ((r_state == ST_GATED) && (r_gated_cnt != C_CNT_MAX)) begin
        r_gated_cnt <= r_gated_cnt + 1'b1;
      end
    end

    assign ch_data_out[i*WIDTH +: WIDTH] = r_data;
    assign gated_cnt[i*CNT_W +: CNT_W]   = r_gated_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_hysteretic_gating_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hysteretic_gating_ctrl
//  Description : Directed self-checking bench for hysteretic_gating_ctrl.
//                The main instance uses default parameters. A second instance
//                with CNT_W=4 shares the stimulus and exercises counter
//                saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hysteretic_gating_ctrl;

  logic         clk;
  logic         rst_n;
  logic [3:0]   force_on;
  logic         gate_disable;
  logic         clr_stats;
  logic [127:0] ch_data_out;
  logic [3:0]   clk_en;
  logic [3:0]   ch_gated;
  logic [63:0]  gated_cnt;
  logic [127:0] ch_data_out_s;
  logic [3:0]   clk_en_s;
  logic [3:0]   ch_gated_s;
  logic [15:0]  gated_cnt_s;

  int n_pass;
  int n_total;

  hysteretic_gating_ctrl_if #(.NUM_CH(4), .WIDTH(32)) bus   ();
  hysteretic_gating_ctrl_if #(.NUM_CH(4), .WIDTH(32)) bus_s ();

  assign bus_s.ch_valid = bus.ch_valid;
  assign bus_s.ch_data  = bus.ch_data;

  hysteretic_gating_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_if        (bus),
    .force_on     (force_on),
    .gate_disable (gate_disable),
    .clr_stats    (clr_stats),
    .ch_data_out  (ch_data_out),
    .clk_en       (clk_en),
    .ch_gated     (ch_gated),
    .gated_cnt    (gated_cnt)
  );

  hysteretic_gating_ctrl #(.CNT_W(4)) dut_s (
    .clk          (clk),
    .rst_n        (rst_n),
    .ch_if        (bus_s),
    .force_on     (force_on),
    .gate_disable (gate_disable),
    .clr_stats    (clr_stats),
    .ch_data_out  (ch_data_out_s),
    .clk_en       (clk_en_s),
    .ch_gated     (ch_gated_s),
    .gated_cnt    (gated_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n active edges and land 1 time unit after the last one.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.ch_valid = '0;
    bus.ch_data  = '0;
    force_on     = '0;
    gate_disable = 1'b0;
    clr_stats    = 1'b0;
    rst_n        = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({ch_data_out, clk_en, ch_gated, gated_cnt, bus.ch_ready} !== {128'h0, 4'hF, 4'h0, 64'h0, 4'hF})
      $display("FAIL reset_values: got data=%h en=%h gated=%h cnt=%h rdy=%h expected 0/F/0/0/F",
               ch_data_out, clk_en, ch_gated, gated_cnt, bus.ch_ready);
    else n_pass++;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      n_total++;
      if ({clk_en, bus.ch_ready} !== 8'hFF)
        $display("FAIL idle_run_edge%0d: got en=%h rdy=%h expected F/F", k, clk_en, bus.ch_ready);
      else n_pass++;
    end
    step(1);
    n_total++;
    if ({clk_en, ch_gated, bus.ch_ready, gated_cnt} !== {4'h0, 4'hF, 4'h0, 64'h0})
      $display("FAIL gate_at_edge8: got en=%h gated=%h rdy=%h cnt=%h expected 0/F/0/0",
               clk_en, ch_gated, bus.ch_ready, gated_cnt);
    else n_pass++;
    step(1);
    n_total++;
    if (gated_cnt !== 64'h0001_0001_0001_0001)
      $display("FAIL gated_cnt_1: got %h expected 0001000100010001", gated_cnt);
    else n_pass++;
    step(1);
    n_total++;
    if (gated_cnt !== 64'h0002_0002_0002_0002)
      $display("FAIL gated_cnt_2: got %h expected 0002000200020002", gated_cnt);
    else n_pass++;
  endtask

  task automatic test_single_transfer();
    do_reset();
    bus.ch_data  = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hDEAD_BEEF};
    bus.ch_valid = 4'b0001;
    step(1);
    n_total++;
    if (ch_data_out !== {96'h0, 32'hDEAD_BEEF})
      $display("FAIL single_capture: got %h expected %h", ch_data_out, {96'h0, 32'hDEAD_BEEF});
    else n_pass++;
    // Back-to-back transfer on the next cycle.
    bus.ch_data[31:0] = 32'h0BAD_F00D;
    step(1);
    n_total++;
    if (ch_data_out !== {96'h0, 32'h0BAD_F00D})
      $display("FAIL back_to_back: got %h expected %h", ch_data_out, {96'h0, 32'h0BAD_F00D});
    else n_pass++;
    bus.ch_valid = 4'b0000;
    bus.ch_data[31:0] = 32'hFFFF_FFFF;
    step(1);
    n_total++;
    if ({ch_data_out[31:0], bus.ch_ready} !== {32'h0BAD_F00D, 4'hF})
      $display("FAIL no_load_without_valid: got data=%h rdy=%h expected 0badf00d/F",
               ch_data_out[31:0], bus.ch_ready);
    else n_pass++;
  endtask

  task automatic test_wake();
    do_reset();
    step(8);
    n_total++;
    if (clk_en[1] !== 1'b0)
      $display("FAIL wake_pre_gated: got clk_en1=%b expected 0", clk_en[1]);
    else n_pass++;
    bus.ch_valid       = 4'b0010;
    bus.ch_data[63:32] = 32'h1234_5678;
    for (int k = 1; k <= 2; k++) begin
      step(1);
      n_total++;
      if ({bus.ch_ready[1], clk_en[1], ch_gated[1]} !== 3'b010)
        $display("FAIL wake_cycle%0d: got rdy/en/gated=%b%b%b expected 010",
                 k, bus.ch_ready[1], clk_en[1], ch_gated[1]);
      else n_pass++;
    end
    step(1);
    n_total++;
    if ({bus.ch_ready[1], ch_data_out[63:32]} !== {1'b1, 32'h0})
      $display("FAIL wake_ready_rise: got rdy=%b data=%h expected 1/00000000",
               bus.ch_ready[1], ch_data_out[63:32]);
    else n_pass++;
    step(1);
    bus.ch_valid = 4'b0000;
    n_total++;
    if ({ch_data_out[63:32], clk_en} !== {32'h1234_5678, 4'b0010})
      $display("FAIL wake_capture: got data=%h en=%h expected 12345678/2",
               ch_data_out[63:32], clk_en);
    else n_pass++;
  endtask

  task automatic test_idle_race();
    do_reset();
    step(7);
    bus.ch_valid        = 4'b0100;
    bus.ch_data[95:64]  = 32'hCAFE_0002;
    step(1);
    bus.ch_valid = 4'b0000;
    n_total++;
    if ({clk_en, bus.ch_ready[2], ch_data_out[95:64]} !== {4'b0100, 1'b1, 32'hCAFE_0002})
      $display("FAIL race_stays_run: got en=%h rdy2=%b data=%h expected 4/1/cafe0002",
               clk_en, bus.ch_ready[2], ch_data_out[95:64]);
    else n_pass++;
    step(7);
    n_total++;
    if (clk_en[2] !== 1'b1)
      $display("FAIL race_idle7: got clk_en2=%b expected 1", clk_en[2]);
    else n_pass++;
    step(1);
    n_total++;
    if (clk_en[2] !== 1'b0)
      $display("FAIL race_idle8: got clk_en2=%b expected 0", clk_en[2]);
    else n_pass++;
  endtask

  task automatic test_overrides();
    do_reset();
    gate_disable = 1'b1;
    bus.ch_valid = 4'b1000;
    bus.ch_data[127:96] = 32'h3C3C_3C3C;
    step(1);
    bus.ch_valid = 4'b0000;
    step(19);
    n_total++;
    if ({clk_en, ch_gated, gated_cnt, ch_data_out[127:96]} !== {4'hF, 4'h0, 64'h0, 32'h3C3C_3C3C})
      $display("FAIL gate_disable_hold: got en=%h gated=%h cnt=%h data3=%h expected F/0/0/3c3c3c3c",
               clk_en, ch_gated, gated_cnt, ch_data_out[127:96]);
    else n_pass++;
    gate_disable = 1'b0;
    step(7);
    n_total++;
    if (clk_en !== 4'hF)
      $display("FAIL release_idle7: got en=%h expected F", clk_en);
    else n_pass++;
    step(1);
    n_total++;
    if (clk_en !== 4'h0)
      $display("FAIL release_gate: got en=%h expected 0", clk_en);
    else n_pass++;
    // Single-cycle force_on pulse still completes the full wake sequence.
    force_on = 4'b1000;
    step(1);
    force_on = 4'b0000;
    n_total++;
    if ({bus.ch_ready[3], clk_en[3]} !== 2'b01)
      $display("FAIL force_wake1: got rdy3/en3=%b%b expected 01", bus.ch_ready[3], clk_en[3]);
    else n_pass++;
    step(1);
    n_total++;
    if ({bus.ch_ready[3], clk_en[3]} !== 2'b01)
      $display("FAIL force_wake2: got rdy3/en3=%b%b expected 01", bus.ch_ready[3], clk_en[3]);
    else n_pass++;
    step(1);
    n_total++;
    if ({bus.ch_ready, clk_en} !== {4'b1000, 4'b1000})
      $display("FAIL force_run: got rdy=%h en=%h expected 8/8", bus.ch_ready, clk_en);
    else n_pass++;
    // Wake channel 0, then reset it mid-WAKE.
    bus.ch_valid = 4'b0001;
    step(1);
    n_total++;
    if ({bus.ch_ready[0], clk_en[0], gated_cnt[15:0] != 16'h0} !== 3'b011)
      $display("FAIL pre_reset_wake: got rdy0/en0/cnt_nz=%b%b%b expected 011",
               bus.ch_ready[0], clk_en[0], gated_cnt[15:0] != 16'h0);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.ch_ready, clk_en, ch_gated, gated_cnt, ch_data_out} !== {4'hF, 4'hF, 4'h0, 64'h0, 128'h0})
      $display("FAIL async_reset_mid_wake: got rdy=%h en=%h gated=%h cnt=%h data=%h expected F/F/0/0/0",
               bus.ch_ready, clk_en, ch_gated, gated_cnt, ch_data_out);
    else n_pass++;
    bus.ch_valid = 4'b0000;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic test_stats();
    do_reset();
    step(8);
    step(20);
    n_total++;
    if ({gated_cnt_s[3:0], gated_cnt[15:0]} !== {4'hF, 16'd20})
      $display("FAIL stats_saturate: got cnt4=%h cnt16=%h expected f/0014",
               gated_cnt_s[3:0], gated_cnt[15:0]);
    else n_pass++;
    clr_stats = 1'b1;
    step(1);
    clr_stats = 1'b0;
    n_total++;
    if ({gated_cnt_s, gated_cnt} !== {16'h0, 64'h0})
      $display("FAIL stats_clear: got cnt4=%h cnt16=%h expected 0/0", gated_cnt_s, gated_cnt);
    else n_pass++;
    step(1);
    n_total++;
    if ({gated_cnt_s, gated_cnt} !== {16'h1111, 64'h0001_0001_0001_0001})
      $display("FAIL stats_resume: got cnt4=%h cnt16=%h expected 1111/0001000100010001",
               gated_cnt_s, gated_cnt);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    test_reset();
    test_single_transfer();
    test_wake();
    test_idle_race();
    test_overrides();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hysteretic_gating_ctrl.md
Name: hysteretic_gating_ctrl

Overview:
Multi-channel, enable-gated capture register bank with a per-channel hysteretic clock-gating controller. Each channel runs its own state machine. The clock enable drops after a programmable run of idle cycles and returns through a wake-up delay before the channel accepts data again. Per-channel clk_en outputs drive downstream ICG cells. Saturating gated-cycle counters report the power-saving residency.

Parameters:
NUM_CH, 4, number of independent channels (>=1)
WIDTH, 32, data width per channel
IDLE_CYCLES, 8, consecutive idle cycles in RUN before gating (>=1)
WAKE_CYCLES, 2, cycles spent in WAKE before ready reasserts (>=0)
CNT_W, 16, width of each gated-cycle statistics counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ch_valid  input  NUM_CH  per-channel data valid; held by source until ready
ch_data  input  NUM_CH*WIDTH  per-channel data, channel i in bits [i*WIDTH +: WIDTH]
ch_ready  output  NUM_CH  channel can accept (state==RUN)
force_on  input  NUM_CH  per-channel gating override
gate_disable  input  1  global override, equivalent to force_on on all channels
clr_stats  input  1  synchronous clear of all gated-cycle counters
ch_data_out  output  NUM_CH*WIDTH  captured data per channel
clk_en  output  NUM_CH  registered clock enable for downstream ICG
ch_gated  output  NUM_CH  status, 1 when state==GATED
gated_cnt  output  NUM_CH*CNT_W  per-channel count of cycles spent in GATED, saturating

Behaviour:
- Reset is asynchronous, active-low (rst_n), on clock clk. On reset every channel is in RUN with idle_cnt=0. Reset values: ch_ready=all 1, clk_en=all 1, ch_gated=0, ch_data_out=0, gated_cnt=0.
- Channels are fully independent. No cross-channel arbitration.
- Transfer: accept = ch_valid[i] & ch_ready[i]. ch_data_out[i] loads ch_data[i] on the accepting edge, so latency is 1 cycle. There is no load without accept.
- act[i] = accept[i] | force_on[i] | gate_disable.
- States per channel (2-bit): RUN, GATED, WAKE.
  - RUN:
    - if act, idle_cnt <= 0.
    - else if idle_cnt == IDLE_CYCLES-1, go to GATED and set idle_cnt <= 0.
    - else idle_cnt++.
  - GATED: on (ch_valid | force_on | gate_disable), go to WAKE with wake_cnt=0. If WAKE_CYCLES==0, go directly to RUN instead.
  - WAKE: wake_cnt++. When wake_cnt == WAKE_CYCLES-1, go to RUN. Overrides do not shorten WAKE.
- ch_ready[i] = (state==RUN). It is combinational from the state register. ch_valid seen in GATED or WAKE is not accepted and must be held by the source.
- clk_en[i] = (state != GATED). It is a direct decode of the state flops, so it is glitch-free. ch_gated = ~clk_en.
- Gating timing: after the last accept at edge t with no further activity, the state is GATED after edge t+IDLE_CYCLES.
- Wake timing: with ch_valid asserted while GATED at edge t, ch_ready rises after edge t+WAKE_CYCLES+1 (t+1 when WAKE_CYCLES==0).
- gated_cnt[i]:
  - increments each cycle the state is GATED and saturates at 2^CNT_W-1 with no wrap.
  - clr_stats has priority over increment, so the counter is 0 on the next cycle even if gated.
- Overrides:
  - force_on or gate_disable held in RUN keeps idle_cnt at 0, so the channel never gates.
  - Either override asserted in GATED triggers the wake sequence exactly as valid does.
- Simultaneous events:
  - An accept on the same edge that idle_cnt would reach terminal keeps the channel in RUN, because act takes priority.
- Reset mid-WAKE or mid-GATED returns the channel to RUN immediately and clears data and stats.
- Width rules:
  - idle_cnt width is $clog2(IDLE_CYCLES+1).
  - wake_cnt width is $clog2(WAKE_CYCLES+1), with a minimum of 1.

Test Plan:
- Use default parameters throughout.
- Reset-state check: reset, release, no stimulus → ch_ready=4'hF and clk_en=4'hF for 7 cycles. clk_en goes to 4'h0 after the 8th edge. gated_cnt then increments by 1 per cycle.
- Single transfer: ch0 valid with data 32'hDEAD_BEEF in RUN → ch_data_out[0]=32'hDEAD_BEEF after 1 edge; channels 1-3 are unchanged.
- Wake sequence: gate ch1, then assert valid with 32'h1234_5678 held → 2 WAKE cycles with ch_ready[1]=0 and clk_en[1]=1. Ready rises on the 3rd cycle, data is captured on the next edge, and the valid is dropped.
- Idle-terminal race: ch2 is idle 7 cycles, then an accept lands on the 8th cycle → ch2 stays in RUN and idle_cnt restarts. It gates only after 8 further idle cycles.
- Overrides and reset: gate_disable held for 20 cycles → no channel gates. Separately, force_on[3] in GATED → WAKE then RUN. Asserting rst_n low mid-WAKE → immediate RUN and zeroed outputs.
- Stats: run with CNT_W=4 and hold ch0 gated for 20 cycles → gated_cnt[0] saturates at 15. Then pulse clr_stats → 0 next cycle, resuming at 1.
